// File: rtl/ctrl_ajuste_hora.sv
// Time-setting controller: arbitrates button ticks, walks an hour/minute/second
// edit sequence on shadow registers, and strobes the timekeeper on commit.
// An edit left idle for TIMEOUT_CYC cycles is abandoned with a one-cycle abort.
//
// state   | meaning
// IDLE    | not editing; shadows hold their last value
// EDIT_H  | editing hour shadow
// EDIT_M  | editing minute shadow
// EDIT_S  | editing second shadow
// COMMIT  | one cycle, wr_en high, timekeeper loads set_*
module ctrl_ajuste_hora #(
  parameter int TIMEOUT_CYC = 50000000,
  parameter int TW          = 26
) (
  input  logic       clkr,
  input  logic       resetr,
  input  logic       tick_mode,
  input  logic       tick_next,
  input  logic       tick_up,
  input  logic       tick_down,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic       edit_active,
  output logic [1:0] field_sel,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       wr_en,
  output logic       abort
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    EDIT_H = 3'd1,
    EDIT_M = 3'd2,
    EDIT_S = 3'd3,
    COMMIT = 3'd4
  } state_t;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          edit_q, edit_d;
  logic [1:0]    field_q, field_d;
  logic          wr_q, wr_d;
  logic          abort_q, abort_d;

  logic in_edit;
  logic acc_mode, acc_next, acc_up, acc_down, acc_any;
  logic expire;

  // Priority arbitration; only the winning tick is acted on, the rest are dropped
  always_comb begin
    in_edit  = (state_q == EDIT_H) || (state_q == EDIT_M) || (state_q == EDIT_S);
    acc_mode = tick_mode;
    acc_next = tick_next & ~tick_mode;
    acc_up   = tick_up & ~tick_mode & ~tick_next;
    acc_down = tick_down & ~tick_mode & ~tick_next & ~tick_up;
    acc_any  = in_edit & (acc_mode | acc_next | acc_up | acc_down);
    expire   = in_edit & ~acc_any & (cnt_q == TO_LAST);
  end

  // State register
  always_ff @(posedge clkr or posedge resetr) begin
    if (resetr) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (tick_mode) state_d = EDIT_H;
      EDIT_H: if (acc_mode) state_d = COMMIT;
              else if (acc_next) state_d = EDIT_M;
              else if (expire) state_d = IDLE;
      EDIT_M: if (acc_mode) state_d = COMMIT;
              else if (acc_next) state_d = EDIT_S;
              else if (expire) state_d = IDLE;
      EDIT_S: if (acc_mode) state_d = COMMIT;
              else if (acc_next) state_d = EDIT_H;
              else if (expire) state_d = IDLE;
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Inactivity counter: runs only while editing with no accepted tick
  always_comb begin
    cnt_d = '0;
    if (in_edit && !acc_any && !expire) cnt_d = cnt_q + TW'(1);
  end

  // Shadow time registers: load on edit entry, step the selected field on up/down
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (state_q == IDLE && tick_mode) begin
      hour_d = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
      min_d  = (cur_min > 6'd59) ? 6'd0 : cur_min;
      sec_d  = (cur_sec > 6'd59) ? 6'd0 : cur_sec;
    end else if (in_edit && (acc_up || acc_down)) begin
      case (state_q)
        EDIT_H: begin
          if (acc_up) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          else        hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
        end
        EDIT_M: begin
          if (acc_up) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          else        min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        end
        EDIT_S: begin
          if (acc_up) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          else        sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Output decode from the upcoming state so that all outputs leave flops
  always_comb begin
    edit_d  = (state_d == EDIT_H) || (state_d == EDIT_M) || (state_d == EDIT_S);
    field_d = 2'd0;
    case (state_d)
      EDIT_H:  field_d = 2'd1;
      EDIT_M:  field_d = 2'd2;
      EDIT_S:  field_d = 2'd3;
      default: field_d = 2'd0;
    endcase
    wr_d    = (state_d == COMMIT);
    abort_d = expire;
  end

  // Datapath and output registers
  always_ff @(posedge clkr or posedge resetr) begin
    if (resetr) begin
      cnt_q   <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      edit_q  <= 1'b0;
      field_q <= 2'd0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      edit_q  <= edit_d;
      field_q <= field_d;
      wr_q    <= wr_d;
      abort_q <= abort_d;
    end
  end

  assign edit_active = edit_q;
  assign field_sel   = field_q;
  assign set_hour    = hour_q;
  assign set_min     = min_q;
  assign set_sec     = sec_q;
  assign wr_en       = wr_q;
  assign abort       = abort_q;

endmodule

// File: tb/tb_ctrl_ajuste_hora.sv
// Directed bench for ctrl_ajuste_hora: a vector table for single-cycle behaviour
// plus hand sequences for timeout and asynchronous reset.
module tb_ctrl_ajuste_hora;

  localparam int TO = 20;

  logic       clkr = 1'b0;
  logic       resetr = 1'b1;
  logic       tick_mode = 1'b0, tick_next = 1'b0, tick_up = 1'b0, tick_down = 1'b0;
  logic [4:0] cur_hour = '0;
  logic [5:0] cur_min = '0, cur_sec = '0;
  logic       edit_active, wr_en, abort;
  logic [1:0] field_sel;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;

  int compared = 0;
  int mismatched = 0;

  ctrl_ajuste_hora #(.TIMEOUT_CYC(TO), .TW(8)) dut (
    .clkr(clkr), .resetr(resetr),
    .tick_mode(tick_mode), .tick_next(tick_next), .tick_up(tick_up), .tick_down(tick_down),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .edit_active(edit_active), .field_sel(field_sel),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .wr_en(wr_en), .abort(abort)
  );

  always #5 clkr = ~clkr;

  typedef struct {
    logic [3:0] ticks;   // {mode,next,up,down}
    logic [4:0] ch;
    logic [5:0] cm, cs;
    logic       ea;
    logic [1:0] fs;
    logic [4:0] h;
    logic [5:0] m, s;
    logic       wr, ab;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] t, logic [4:0] ch, logic [5:0] cm, logic [5:0] cs,
                              logic ea, logic [1:0] fs, logic [4:0] h, logic [5:0] m,
                              logic [5:0] s, logic wr, logic ab);
    vec_t v;
    v.ticks = t; v.ch = ch; v.cm = cm; v.cs = cs;
    v.ea = ea; v.fs = fs; v.h = h; v.m = m; v.s = s; v.wr = wr; v.ab = ab;
    return v;
  endfunction

  task automatic set_ticks(input logic [3:0] t);
    {tick_mode, tick_next, tick_up, tick_down} = t;
  endtask

  task automatic step();
    @(posedge clkr);
    #1;
  endtask

  task automatic expect_out(input string name, input logic ea, input logic [1:0] fs,
                            input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                            input logic wr, input logic ab);
    compared++;
    if ({edit_active, field_sel, set_hour, set_min, set_sec, wr_en, abort} !==
        {ea, fs, h, m, s, wr, ab}) begin
      mismatched++;
      $display("FAIL %s: got ea=%b fs=%0d %0d:%0d:%0d wr=%b ab=%b, want ea=%b fs=%0d %0d:%0d:%0d wr=%b ab=%b",
               name, edit_active, field_sel, set_hour, set_min, set_sec, wr_en, abort,
               ea, fs, h, m, s, wr, ab);
    end
  endtask

  initial begin
    // {mode,next,up,down}, cur h/m/s, expected ea fs h m s wr ab
    vecs.push_back(mk(4'b0000, 12, 34, 56, 0, 0,  0,  0,  0, 0, 0));
    vecs.push_back(mk(4'b0010, 12, 34, 56, 0, 0,  0,  0,  0, 0, 0)); // up ignored in IDLE
    vecs.push_back(mk(4'b1000, 12, 34, 56, 1, 1, 12, 34, 56, 0, 0)); // enter edit
    vecs.push_back(mk(4'b1000, 12, 34, 56, 0, 0, 12, 34, 56, 1, 0)); // commit
    vecs.push_back(mk(4'b0000, 12, 34, 56, 0, 0, 12, 34, 56, 0, 0));
    vecs.push_back(mk(4'b0000, 23,  0,  0, 0, 0, 12, 34, 56, 0, 0)); // not tracked
    vecs.push_back(mk(4'b1000, 23,  0,  0, 1, 1, 23,  0,  0, 0, 0));
    vecs.push_back(mk(4'b0010, 23,  0,  0, 1, 1,  0,  0,  0, 0, 0)); // 23 -> 0
    vecs.push_back(mk(4'b0001, 23,  0,  0, 1, 1, 23,  0,  0, 0, 0)); // 0 -> 23
    vecs.push_back(mk(4'b0100, 23,  0,  0, 1, 2, 23,  0,  0, 0, 0));
    vecs.push_back(mk(4'b0100, 23,  0,  0, 1, 3, 23,  0,  0, 0, 0));
    vecs.push_back(mk(4'b0001, 23,  0,  0, 1, 3, 23,  0, 59, 0, 0)); // sec 0 -> 59
    vecs.push_back(mk(4'b0100, 23,  0,  0, 1, 1, 23,  0, 59, 0, 0)); // field wrap
    vecs.push_back(mk(4'b0001, 23,  0,  0, 1, 1, 22,  0, 59, 0, 0));
    vecs.push_back(mk(4'b0100, 23,  0,  0, 1, 2, 22,  0, 59, 0, 0));
    vecs.push_back(mk(4'b1110, 23,  0,  0, 0, 0, 22,  0, 59, 1, 0)); // mode wins
    vecs.push_back(mk(4'b0000, 23,  0,  0, 0, 0, 22,  0, 59, 0, 0));
    vecs.push_back(mk(4'b1000, 27, 60, 59, 1, 1,  0,  0, 59, 0, 0)); // out-of-range -> 0
    vecs.push_back(mk(4'b0011, 27, 60, 59, 1, 1,  1,  0, 59, 0, 0)); // up beats down
    vecs.push_back(mk(4'b0101, 27, 60, 59, 1, 2,  1,  0, 59, 0, 0)); // next beats down
    vecs.push_back(mk(4'b0001, 27, 60, 59, 1, 2,  1, 59, 59, 0, 0)); // min 0 -> 59
    vecs.push_back(mk(4'b0010, 27, 60, 59, 1, 2,  1,  0, 59, 0, 0)); // min 59 -> 0
    vecs.push_back(mk(4'b0001, 27, 60, 59, 1, 2,  1, 59, 59, 0, 0));
    vecs.push_back(mk(4'b1000, 27, 60, 59, 0, 0,  1, 59, 59, 1, 0)); // commit
    vecs.push_back(mk(4'b1010, 12, 34, 56, 0, 0,  1, 59, 59, 0, 0)); // ticks in COMMIT ignored
    vecs.push_back(mk(4'b0000, 12, 34, 56, 0, 0,  1, 59, 59, 0, 0));

    // reset state
    step();
    expect_out("reset_hold", 0, 0, 0, 0, 0, 0, 0);
    step();
    resetr = 1'b0;
    step();
    expect_out("after_reset", 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      set_ticks(vecs[i].ticks);
      cur_hour = vecs[i].ch; cur_min = vecs[i].cm; cur_sec = vecs[i].cs;
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].ea, vecs[i].fs, vecs[i].h, vecs[i].m,
                 vecs[i].s, vecs[i].wr, vecs[i].ab);
    end
    set_ticks(4'b0000);

    // timeout with no ticks: abort exactly TO edges after the entry edge
    cur_hour = 5; cur_min = 6; cur_sec = 7;
    set_ticks(4'b1000);
    step();
    set_ticks(4'b0000);
    expect_out("to_entry", 1, 1, 5, 6, 7, 0, 0);
    for (int k = 1; k < TO; k++) begin
      step();
      expect_out($sformatf("to_wait%0d", k), 1, 1, 5, 6, 7, 0, 0);
    end
    step();
    expect_out("to_abort", 0, 0, 5, 6, 7, 0, 1);
    step();
    expect_out("to_after", 0, 0, 5, 6, 7, 0, 0);

    // tick on the would-be expiry cycle wins and restarts the count
    set_ticks(4'b1000);
    step();
    set_ticks(4'b0000);
    for (int k = 1; k < TO; k++) step();
    expect_out("tw_pre", 1, 1, 5, 6, 7, 0, 0);
    set_ticks(4'b0010);
    step();
    set_ticks(4'b0000);
    expect_out("tw_tick", 1, 1, 6, 6, 7, 0, 0);
    for (int k = 1; k < TO; k++) begin
      step();
      if (abort || wr_en) expect_out($sformatf("tw_wait%0d", k), 1, 1, 6, 6, 7, 0, 0);
    end
    expect_out("tw_last_wait", 1, 1, 6, 6, 7, 0, 0);
    step();
    expect_out("tw_abort", 0, 0, 6, 6, 7, 0, 1);

    // asynchronous reset in the middle of EDIT_S
    cur_hour = 9; cur_min = 8; cur_sec = 7;
    set_ticks(4'b1000); step();
    set_ticks(4'b0100); step();
    set_ticks(4'b0100); step();
    set_ticks(4'b0000);
    expect_out("rs_edit_s", 1, 3, 9, 8, 7, 0, 0);
    #2 resetr = 1'b1;
    #1 expect_out("rs_async", 0, 0, 0, 0, 0, 0, 0);
    step();
    expect_out("rs_held", 0, 0, 0, 0, 0, 0, 0);
    resetr = 1'b0;
    set_ticks(4'b0111); step();
    expect_out("rs_ign1", 0, 0, 0, 0, 0, 0, 0);
    set_ticks(4'b0001); step();
    expect_out("rs_ign2", 0, 0, 0, 0, 0, 0, 0);
    set_ticks(4'b1000); step();
    set_ticks(4'b0000);
    expect_out("rs_reenter", 1, 1, 9, 8, 7, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ctrl_ajuste_hora.md
Name: ctrl_ajuste_hora

Overview:
- Button-driven time-setting controller for the clock design; consumes the single-cycle ticks produced by the per-button debounce/tick blocks.
- Arbitrates simultaneous button ticks and sequences an edit FSM (hour -> minute -> second).
- Holds shadow time registers and issues a one-cycle write strobe to the timekeeping counter on commit; aborts on an inactivity timeout.

Parameters:
TIMEOUT_CYC, 50000000, idle clock cycles in an edit state before the edit is abandoned (bench overrides to a small value, e.g. 20)
TW, 26, width of the timeout counter; must satisfy 2^TW > TIMEOUT_CYC

Ports:
clkr  input  1  system clock, all logic on rising edge
resetr  input  1  asynchronous, active-high reset
tick_mode  input  1  one-cycle pulse: enter edit / commit
tick_next  input  1  one-cycle pulse: advance edited field
tick_up  input  1  one-cycle pulse: increment current field
tick_down  input  1  one-cycle pulse: decrement current field
cur_hour  input  5  live hour from timekeeper, 0..23
cur_min  input  6  live minute, 0..59
cur_sec  input  6  live second, 0..59
edit_active  output  1  high in any EDIT state
field_sel  output  2  0 none, 1 hour, 2 minute, 3 second (for display blinking)
set_hour  output  5  shadow hour
set_min  output  6  shadow minute
set_sec  output  6  shadow second
wr_en  output  1  one-cycle strobe: timekeeper loads set_* this cycle
abort  output  1  one-cycle pulse: edit abandoned by timeout

Behaviour:
- Clock is clkr; reset is asynchronous and active-high on resetr. While resetr=1: state IDLE, shadows 0, timeout counter 0, all outputs 0.
- All outputs are registered. A tick sampled at edge n is reflected on the outputs after edge n.
- Arbitration: when multiple ticks are high in the same cycle, accept only one, with priority mode > next > up > down. Lower-priority ticks are dropped, not queued.
- States: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- IDLE:
  - tick_mode -> EDIT_H.
  - On entry, load shadows from cur_*. Any out-of-range value (hour>23, min/sec>59) loads as 0.
  - Other ticks are ignored.
- EDIT_x:
  - tick_mode -> COMMIT.
  - tick_next -> EDIT_H->EDIT_M->EDIT_S->EDIT_H.
  - tick_up increments the selected shadow: hour 23->0, min/sec 59->0.
  - tick_down decrements: hour 0->23, min/sec 0->59.
  - Unselected shadows are held.
- COMMIT:
  - Lasts exactly one cycle with wr_en=1 and set_* stable; next state IDLE unconditionally.
  - All ticks during COMMIT are ignored.
- Outputs by state:
  - field_sel = 1/2/3 in EDIT_H/M/S, else 0.
  - edit_active = 1 only in EDIT_*.
  - set_* are held in IDLE after a commit or abort; they are not tracked to cur_*.
- Timeout:
  - Counter clears on entry to EDIT_H and on every accepted tick; increments each cycle in EDIT_* with no accepted tick.
  - When the counter equals TIMEOUT_CYC-1 with no accepted tick: next state IDLE, abort=1 for one cycle, wr_en stays 0, shadows retained.
  - Tick and expiry in the same cycle: the tick wins and the counter clears.
  - Counter is held at 0 outside EDIT_*.
- Reset mid-edit: immediate return to IDLE, no wr_en, shadows 0.
- Exactly one of wr_en/abort can be high per cycle; neither is high outside the COMMIT exit or the timeout exit.

Test Plan:
- Reset, then cur=12:34:56 and tick_mode -> next cycle edit_active=1, field_sel=1, set_*=12/34/56; tick_mode again -> wr_en=1 for exactly one cycle with 12/34/56, then IDLE.
- In EDIT_H with hour=23, tick_up -> 0; tick_down -> 23; tick_next x2, sec=0, tick_down -> 59; tick_next -> field_sel=1 (wrap).
- tick_mode, tick_next and tick_up all high in the same cycle while in EDIT_M -> COMMIT only; minute unchanged and field not advanced.
- TIMEOUT_CYC=20: enter edit, no ticks -> abort=1 exactly 20 cycles after the entry edge, wr_en never 1; with tick_up at cycle 19 -> no abort and the counter restarts.
- cur_hour=27, cur_min=60 on entry -> set_hour=0, set_min=0; ticks applied during COMMIT have no effect.
- resetr asserted asynchronously mid-EDIT_S -> outputs 0 before the next edge; after release, ticks other than tick_mode are ignored.
